// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory load/store unit.
package mem_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2,
    SizeBad  = 2'd3
  } mem_size_e;

  typedef enum logic {
    StClear,
    StRun
  } lsu_state_e;

  localparam int unsigned ByteW    = 8;
  localparam int unsigned HalfW    = 16;
  localparam int unsigned WordW    = 32;
  localparam int unsigned NumLanes = 4;

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bus between a requester (master) and the load/store unit (slave).
interface data_mem_lsu_if;
  import mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  mem_size_e   req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_array.sv
// DEPTH x 32-bit storage with per-byte write enables, synchronous write-first read.
module data_mem_array #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic [3:0]               we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rd_merged;

  // Bypass bytes being written this edge so a same-address read sees the new data.
  always_comb begin
    rd_merged = mem_q[raddr_i];
    for (int b = 0; b < 4; b++) begin
      if (we_i[b] && (waddr_i == raddr_i)) begin
        rd_merged[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  // Byte-enabled write and registered read.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= rd_merged;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit: post-reset clear sweep, access checking, lane steering and load extension.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter bit          OUT_REG        = 1'b0
) (
  input logic           clk,
  input logic           rst,
  data_mem_lsu_if.slave bus
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  lsu_state_e       state_q, state_d;
  logic [AddrW-1:0] sweep_q, sweep_d;
  logic             ready;
  logic             accept;
  logic             err;
  logic [AddrW-1:0] word_idx;
  logic [1:0]       lane;
  logic [3:0]       be;
  logic [31:0]      wdata_lanes;
  logic [3:0]       mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  // Stage 1: request attributes aligned with the array read data.
  logic             s1_valid_q;
  logic             s1_load_q;
  logic             s1_err_q;
  logic [1:0]       s1_lane_q;
  mem_size_e        s1_size_q;
  logic             s1_uns_q;
  logic [31:0]      rsp_data;

  assign word_idx = bus.req_addr[AddrW+1:2];
  assign lane     = bus.req_addr[1:0];
  assign accept   = bus.req_valid && ready;

  // Faults: illegal size, misalignment, or an address past the last word.
  assign err = (bus.req_size == SizeBad)
            || ((bus.req_size == SizeHalf) && bus.req_addr[0])
            || ((bus.req_size == SizeWord) && (bus.req_addr[1:0] != 2'b00))
            || (|bus.req_addr[31:AddrW+2]);

  // FSM state and sweep counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR_ON_RESET ? StClear : StRun;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next state: sweep one word per cycle, then run forever.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready   = 1'b0;
    unique case (state_q)
      StClear: begin
        if (sweep_q == AddrW'(DEPTH - 1)) begin
          state_d = StRun;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      StRun:   ready = 1'b1;
      default: state_d = StRun;
    endcase
  end

  // Store lane steering: replicate right-aligned data across lanes, enable the target bytes.
  always_comb begin
    be          = '0;
    wdata_lanes = '0;
    unique case (bus.req_size)
      SizeByte: begin
        be          = 4'b0001 << lane;
        wdata_lanes = {NumLanes{bus.req_wdata[ByteW-1:0]}};
      end
      SizeHalf: begin
        be          = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{bus.req_wdata[HalfW-1:0]}};
      end
      SizeWord: begin
        be          = 4'hF;
        wdata_lanes = bus.req_wdata;
      end
      default: ;
    endcase
  end

  // Array write port is owned by the sweep while clearing.
  always_comb begin
    if (state_q == StClear) begin
      mem_we    = 4'hF;
      mem_waddr = sweep_q;
      mem_wdata = '0;
    end else begin
      mem_we    = (accept && bus.req_write && !err) ? be : 4'h0;
      mem_waddr = word_idx;
      mem_wdata = wdata_lanes;
    end
  end

  data_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .raddr_i(word_idx),
    .rdata_o(mem_rdata)
  );

  // Capture request attributes on the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_load_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_lane_q  <= '0;
      s1_size_q  <= SizeByte;
      s1_uns_q   <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_load_q  <= accept && !bus.req_write && !err;
      s1_err_q   <= accept && err;
      s1_lane_q  <= lane;
      s1_size_q  <= bus.req_size;
      s1_uns_q   <= bus.req_unsigned;
    end
  end

  // Load extraction and extension; stores and faults return zero.
  always_comb begin
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    ld_byte  = mem_rdata[{s1_lane_q, 3'b000} +: 8];
    ld_half  = s1_lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rsp_data = '0;
    if (s1_load_q) begin
      unique case (s1_size_q)
        SizeByte: rsp_data = {{24{!s1_uns_q && ld_byte[7]}}, ld_byte};
        SizeHalf: rsp_data = {{16{!s1_uns_q && ld_half[15]}}, ld_half};
        SizeWord: rsp_data = mem_rdata;
        default:  rsp_data = '0;
      endcase
    end
  end

  assign bus.req_ready = ready;

  if (OUT_REG) begin : g_out_reg
    logic        s2_valid_q;
    logic [31:0] s2_rdata_q;
    logic        s2_err_q;

    // Optional output stage adds one cycle of response latency.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s2_valid_q <= 1'b0;
        s2_rdata_q <= '0;
        s2_err_q   <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_rdata_q <= rsp_data;
        s2_err_q   <= s1_err_q;
      end
    end

    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_rdata = s2_rdata_q;
    assign bus.rsp_err   = s2_err_q;
  end else begin : g_out_comb
    assign bus.rsp_valid = s1_valid_q;
    assign bus.rsp_rdata = rsp_data;
    assign bus.rsp_err   = s1_err_q;
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench: two DUTs (OUT_REG=0 and OUT_REG=1) driven identically, checked against a word-array model.
module tb_data_mem_lsu;
  import mem_pkg::*;

  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_lsu_if bus0 ();
  data_mem_lsu_if bus1 ();

  data_mem_lsu #(.DEPTH(Depth), .CLEAR_ON_RESET(1'b1), .OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  data_mem_lsu #(.DEPTH(Depth), .CLEAR_ON_RESET(1'b1), .OUT_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        e;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  logic [31:0] mem_m [Depth];
  rsp_t        p1, p2;
  int unsigned sweep_left;
  int          total = 0;
  int          bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference behaviour from the access rules, on a plain word array.
  function automatic rsp_t model_access(logic wr, logic [1:0] sz, logic uns, logic [31:0] a,
                                        logic [31:0] wd);
    rsp_t        r;
    int unsigned idx;
    int unsigned ln;
    logic [31:0] w;
    r.v = 1'b1;
    r.d = '0;
    r.e = 1'b0;
    if (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
        || a >= 4 * Depth) begin
      r.e = 1'b1;
      return r;
    end
    idx = a / 4;
    ln  = a % 4;
    w   = mem_m[idx];
    if (wr) begin
      case (sz)
        2'd0:    w[8*ln +: 8] = wd[7:0];
        2'd1:    w[8*ln +: 16] = wd[15:0];
        default: w = wd;
      endcase
      mem_m[idx] = w;
    end else begin
      case (sz)
        2'd0: begin
          r.d = (w >> (8 * ln)) & 32'hFF;
          if (!uns && r.d[7]) r.d = r.d | 32'hFFFF_FF00;
        end
        2'd1: begin
          r.d = (w >> (8 * ln)) & 32'hFFFF;
          if (!uns && r.d[15]) r.d = r.d | 32'hFFFF_0000;
        end
        default: r.d = w;
      endcase
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bus0.req_valid = v;   bus1.req_valid = v;
    bus0.req_write = wr;  bus1.req_write = wr;
    bus0.req_size = mem_size_e'(sz);  bus1.req_size = mem_size_e'(sz);
    bus0.req_unsigned = uns;  bus1.req_unsigned = uns;
    bus0.req_addr = a;    bus1.req_addr = a;
    bus0.req_wdata = wd;  bus1.req_wdata = wd;
  endtask

  // One clock: drive, check at negedge, advance model on the posedge.
  task automatic step(input logic v, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input bit ovr,
                      input logic [31:0] xd, input logic xe);
    rsp_t nr;
    logic acc;
    drive(v, wr, sz, uns, a, wd);
    @(negedge clk);
    check("ready0", {31'b0, bus0.req_ready}, {31'b0, sweep_left == 0});
    check("ready1", {31'b0, bus1.req_ready}, {31'b0, sweep_left == 0});
    check("rsp_valid0", {31'b0, bus0.rsp_valid}, {31'b0, p1.v});
    if (p1.v) begin
      check("rsp_rdata0", bus0.rsp_rdata, p1.d);
      check("rsp_err0", {31'b0, bus0.rsp_err}, {31'b0, p1.e});
    end
    check("rsp_valid1", {31'b0, bus1.rsp_valid}, {31'b0, p2.v});
    if (p2.v) begin
      check("rsp_rdata1", bus1.rsp_rdata, p2.d);
      check("rsp_err1", {31'b0, bus1.rsp_err}, {31'b0, p2.e});
    end
    acc = v && (sweep_left == 0);
    @(posedge clk);
    nr.v = 1'b0;
    nr.d = '0;
    nr.e = 1'b0;
    if (acc) begin
      nr = model_access(wr, sz, uns, a, wd);
      if (ovr) begin
        nr.d = xd;
        nr.e = xe;
      end
    end
    if (sweep_left > 0) sweep_left--;
    p2 = p1;
    p1 = nr;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    p1 = '{v: 1'b0, d: 32'h0, e: 1'b0};
    p2 = '{v: 1'b0, d: 32'h0, e: 1'b0};
    for (int i = 0; i < Depth; i++) mem_m[i] = '0;
    sweep_left = Depth;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_valid0", {31'b0, bus0.rsp_valid}, 32'h0);
      check("rst_valid1", {31'b0, bus1.rsp_valid}, 32'h0);
      check("rst_rdata0", bus0.rsp_rdata, 32'h0);
      check("rst_rdata1", bus1.rsp_rdata, 32'h0);
      check("rst_err0", {31'b0, bus0.rsp_err | bus1.rsp_err}, 32'h0);
      check("rst_ready", {30'b0, bus0.req_ready, bus1.req_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  // Sweep phase with a request held valid: it must not be accepted until ready rises.
  task automatic wait_sweep();
    for (int i = 0; i < Depth + 4 && sweep_left > 0; i++) begin
      step(1'b1, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 1'b0, 32'h0, 1'b0);
    end
  endtask

  task automatic rand_steps(input int n);
    logic        v, wr, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      wr  = $urandom_range(0, 1) != 0;
      uns = $urandom_range(0, 1) != 0;
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * Depth - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      step(v, wr, sz, uns, a, $urandom, 1'b0, 32'h0, 1'b0);
    end
  endtask

  vec_t        vecs [20];
  logic [31:0] d;

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    p1 = '{v: 1'b0, d: 32'h0, e: 1'b0};
    p2 = '{v: 1'b0, d: 32'h0, e: 1'b0};
    @(posedge clk);
    #1;
    do_reset(3);
    wait_sweep();

    //          wr    sz    uns   addr      wdata           exp_d           exp_e
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0,          32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01,  32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,          32'h0000_007F, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,          32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,          32'h0000_0080, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,          32'hFFFF_80FF, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,          32'h0000_80FF, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344,  32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFF_FFAA,  32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,          32'h1122_AA44, 1'b0};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h01, 32'h0,          32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,          32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h20, 32'h0,          32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,          32'h0000_0000, 1'b1};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF,  32'h0000_0000, 1'b1};
    vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h23, 32'h0000_5555,  32'h0000_0000, 1'b1};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,          32'h1122_AA44, 1'b0};
    vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,          32'h0000_0000, 1'b0};
    vecs[18] = '{1'b1, 2'd1, 1'b0, 32'h1E, 32'h1234_BEEF,  32'h0000_0000, 1'b0};
    vecs[19] = '{1'b0, 2'd2, 1'b0, 32'h1C, 32'h0,          32'hBEEF_0000, 1'b0};
    for (int i = 0; i < 20; i++) begin
      step(1'b1, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 1'b1,
           vecs[i].exp_d, vecs[i].exp_e);
    end
    idle(2);

    // Back-to-back store/load pairs at one word; each load must see the store before it.
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      step(1'b1, 1'b1, 2'd2, 1'b0, 32'h08, d, 1'b1, 32'h0, 1'b0);
      step(1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 1'b1, d, 1'b0);
    end
    idle(2);

    rand_steps(250);

    // Reset with a load still in flight: no response may emerge.
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0, 1'b0);
    do_reset(2);
    idle(7);
    // Reset again mid-sweep; the sweep must restart and take the full depth.
    do_reset(1);
    wait_sweep();
    rand_steps(250);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words; SHALL be a power of two, 16..65536.
REQ-002 Parameter CLEAR_ON_RESET, default 1, enables the post-reset zero sweep.
REQ-003 Parameter OUT_REG, default 0, adds one output register stage (read latency 1 -> 2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  access size, mem_size_e: BYTE=0, HALF=1, WORD=2; 3 illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 rsp_valid  output  1  response present, single-cycle pulse per accepted request.
REQ-014 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  access faulted (misaligned, out of range or illegal size).

Function
REQ-016 FSM states SHALL be CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-017 CLEAR: one word per cycle written to zero, index 0..DEPTH-1; req_ready=0; after writing index DEPTH-1, go to RUN on the next edge.
REQ-018 RUN: req_ready=1 every cycle; no response back-pressure.
REQ-019 Accept = req_valid && req_ready; at most one request per cycle.
REQ-020 Word index = req_addr[$clog2(DEPTH)+1:2]; lane = req_addr[1:0].
REQ-021 Error, checked in order: req_size=3; HALF with addr[0]=1; WORD with addr[1:0]!=0; addr >= 4*DEPTH. Any error -> no memory write, rsp_err=1, rsp_rdata=0.
REQ-022 SB writes byte lane addr[1:0] from wdata[7:0]; SH writes lanes addr[1]*2+{0,1} from wdata[15:0]; SW writes all lanes. Other lanes are unchanged; the write is committed on the accept edge.
REQ-023 Load: synchronous read of the word; select byte/half by lane; extend per req_unsigned (ignored for WORD).
REQ-024 rsp_valid SHALL assert exactly 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) after the accept edge, with rsp_rdata/rsp_err valid in the same cycle.
REQ-025 Full throughput: back-to-back accepts produce back-to-back responses in order.
REQ-026 A load accepted the cycle after a store to the same word SHALL return the updated data (write-first).
REQ-027 Stores produce a response (rsp_err as per REQ-021, rsp_rdata=0).

Reset
REQ-028 On rst low: FSM to CLEAR/RUN per REQ-016, sweep index=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, pipeline valids=0.
REQ-029 Reset asserted mid-sweep or mid-pipeline SHALL discard in-flight responses and restart the sweep from index 0.
REQ-030 With CLEAR_ON_RESET=0, memory contents are not reset.

Structure
REQ-031 Package mem_pkg SHALL hold mem_size_e and the lane/extension helper constants.
REQ-032 Storage SHALL be the sub-module data_mem_array: DEPTH x 32 bits, 4 byte-write enables, synchronous read, write-first.
REQ-033 The FSM, sweep counter, alignment check, lane steering and extension SHALL live in data_mem_lsu.

Verification
REQ-034 Reset release, CLEAR_ON_RESET=1, DEPTH=16 -> req_ready low 16 cycles, then high; LW from 0x3C -> rdata 0x00000000.
REQ-035 SW 0x80FF7F01 @0x10, then LB/LBU/LH/LHU @0x11, 0x13, 0x12 -> LB@0x11=0x0000007F, LB@0x13=0xFFFFFF80, LBU@0x13=0x00000080, LH@0x12=0xFFFF80FF, LHU@0x12=0x000080FF.
REQ-036 SB 0xAA @0x21 over word 0x11223344 -> LW @0x20 returns 0x1122AA44.
REQ-037 LH @0x01, LW @0x06, size=3, LW @4*DEPTH -> each rsp_err=1, rdata=0; memory is unchanged.
REQ-038 OUT_REG=1, 8 back-to-back SW then LW, alternating at one address -> 8 responses, each 2 cycles after its accept; every load returns the preceding store's data.
REQ-039 Reset asserted at sweep index 7 -> rsp_valid=0, the sweep restarts at index 0, and req_ready stays low for a further DEPTH cycles.
